te_transmission_recip: RTL and testbench
========================================

Name: te_transmission_recip

Overview:
- Stage directly downstream of the ω·min(Pc/Ac) multiplier in the transmission-estimation (TE) path.
- Input: the multiplier's Q0.10 product, one pixel per clock.
- Computes transmission t = 1 − product and clamps it to a lower bound t0.
- Produces t and its reciprocal 1/t for the scene-radiance recovery stage, using a fully pipelined restoring divider (throughput 1 pixel/clk, fixed latency).

Parameters:
- T0, 103, lower clamp for t in Q0.10 (≈0.1); legal range 1..1023.
- Q_BITS, 14, quotient width of the reciprocal (Q4.10); must satisfy 2^20/T0 < 2^Q_BITS.

Ports:
- clk  input  1  pixel clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  product qualifier, aligned with product at this port.
- in_sof  input  1  start-of-frame sideband, aligned with in_valid.
- product  input  10  ω·min(Pc/Ac), Q0.10 unsigned.
- out_valid  output  1  result qualifier.
- out_sof  output  1  in_sof delayed to align with out_valid.
- t_out  output  11  clamped transmission, Q1.10 (1024 = 1.0).
- inv_t  output  14  floor(2^20 / t_out), Q4.10.
- clamped  output  1  high when t was raised to T0 for this pixel.

Behaviour:
- Reset: asynchronous assert on rst_n low, synchronous release. Every valid/sof pipeline flag, out_valid, out_sof, t_out, inv_t and clamped reset to 0.
- Datapath registers need not reset, but outputs must read 0 until the first valid result reaches them.
- Pipeline, LAT = Q_BITS + 3 = 17 cycles:
  - S0 registers the inputs.
  - S1 computes t_raw = 1024 − product (11-bit, range 1..1024), then t = max(t_raw, T0); clamped = (t_raw < T0).
  - S2..S(Q_BITS+1) are restoring divider stages, one quotient bit per stage, MSB first.
  - The final stage registers the outputs.
- Timing: out_valid asserts exactly LAT cycles after in_valid is sampled high. out_sof, t_out and clamped travel in lockstep with their pixel.
- Throughput: a new pixel is accepted every cycle. No backpressure and no stall input. in_valid may be high on any subset of cycles, including back-to-back.
- Bubbles: cycles with in_valid = 0 propagate as bubbles with out_valid = 0. Output data during bubbles is don't-care but must not be X after reset.
- Division:
  - Dividend is the constant 2^20, divisor is t (≥ T0 ≥ 1), so divide-by-zero cannot occur.
  - Result is truncated, never rounded.
  - t = 1024 gives inv_t = 1024 exactly.
  - No saturation logic is needed given the parameter constraint.
- Arithmetic is unsigned throughout. product is at most 1023, so t_raw never underflows.
- Boundaries:
  - t_raw == T0 is not clamped (clamped = 0).
  - t_raw == T0 − 1 is clamped.
- Reset mid-stream: all in-flight pixels are discarded, and out_valid stays 0 for LAT cycles after the first post-reset in_valid.
- in_sof is passed through unconditionally.
- in_sof with in_valid = 0 is legal and propagates as out_sof with out_valid = 0.

Test Plan:
- product = 0, in_valid pulse → after 17 cycles: out_valid = 1, t_out = 1024, inv_t = 1024, clamped = 0.
- product = 512 → t_out = 512, inv_t = 2048, clamped = 0. product = 1000 → t_out = 103, inv_t = 10180, clamped = 1.
- Clamp boundary, back-to-back: product = 921 then 922 → t_out = 103 for both, inv_t = 10180 for both, clamped = 0 then 1.
- Streaming: 1000 consecutive random products with random in_valid gaps and an in_sof on the first valid. Outputs match the reference model floor(2^20/max(1024−p, 103)). Order, count and sof alignment are exact, and every latency is 17.
- Reset at cycle 8 with 5 pixels in flight → no out_valid emerges from those pixels. The next pixel emerges exactly 17 cycles after its in_valid.
- Sweep: product = 0..1023 exhaustive → t_out and inv_t match the model for every code, and inv_t never exceeds 10180.

Source files
------------

// File: rtl/te_transmission_recip.sv
// Transmission clamp and reciprocal: t = max(1024 - product, T0), inv_t = floor(2^20 / t).
// Fully pipelined (one pixel per clock), fixed latency Q_BITS + 3 cycles.
module te_transmission_recip #(
  parameter int T0     = 103,
  parameter int Q_BITS = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_sof,
  input  logic [9:0]        product,
  output logic              out_valid,
  output logic              out_sof,
  output logic [10:0]       t_out,
  output logic [Q_BITS-1:0] inv_t,
  output logic              clamped
);

  // Valid semantics: in_valid qualifies product on the cycle it is high; there is
  // no ready, every cycle is accepted, and out_valid marks the same pixel LAT cycles later.

  localparam logic [10:0] T0_L     = 11'(T0);
  localparam logic [10:0] ONE_Q10  = 11'd1024;
  // Dividend bits above the quotient window; smaller than any legal t.
  localparam logic [10:0] REM_INIT = 11'(1 << (20 - Q_BITS));

  // S0: input capture
  logic       s0_valid;
  logic       s0_sof;
  logic [9:0] s0_product;

  // S1 combinational: transmission and clamp
  logic [10:0] s1_t_raw;
  logic [10:0] s1_t;
  logic        s1_clamp;

  // Divider pipeline: index 0 is the S1 register, index j is after quotient bit j
  logic              dv_valid [0:Q_BITS];
  logic              dv_sof   [0:Q_BITS];
  logic              dv_clamp [0:Q_BITS];
  logic [10:0]       dv_t     [0:Q_BITS];
  logic [10:0]       dv_rem   [0:Q_BITS];
  logic [Q_BITS-1:0] dv_q     [0:Q_BITS];

  logic [11:0] trial   [1:Q_BITS];
  logic        ge      [1:Q_BITS];
  logic [10:0] rem_nxt [1:Q_BITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_sof   <= 1'b0;
      for (int j = 0; j <= Q_BITS; j++) begin
        dv_valid[j] <= 1'b0;
        dv_sof[j]   <= 1'b0;
      end
    end else begin
      s0_valid    <= in_valid;
      s0_sof      <= in_sof;
      dv_valid[0] <= s0_valid;
      dv_sof[0]   <= s0_sof;
      for (int j = 1; j <= Q_BITS; j++) begin
        dv_valid[j] <= dv_valid[j-1];
        dv_sof[j]   <= dv_sof[j-1];
      end
    end
  end

  always_comb begin
    s1_t_raw = ONE_Q10 - {1'b0, s0_product};
    s1_clamp = (s1_t_raw < T0_L);
    s1_t     = s1_clamp ? T0_L : s1_t_raw;
  end

  // Restoring step: remainder stays below t, so the shifted trial fits 12 bits
  // and the difference fits 11 bits whenever it is taken.
  always_comb begin
    for (int j = 1; j <= Q_BITS; j++) begin
      trial[j]   = {dv_rem[j-1], 1'b0};
      ge[j]      = (trial[j] >= {1'b0, dv_t[j-1]});
      rem_nxt[j] = ge[j] ? (trial[j][10:0] - dv_t[j-1]) : trial[j][10:0];
    end
  end

  always_ff @(posedge clk) begin
    s0_product  <= product;
    dv_t[0]     <= s1_t;
    dv_rem[0]   <= REM_INIT;
    dv_q[0]     <= '0;
    dv_clamp[0] <= s1_clamp;
    for (int j = 1; j <= Q_BITS; j++) begin
      dv_t[j]     <= dv_t[j-1];
      dv_rem[j]   <= rem_nxt[j];
      dv_q[j]     <= {dv_q[j-1][Q_BITS-2:0], ge[j]};
      dv_clamp[j] <= dv_clamp[j-1];
    end
  end

  // Output data only loads on valid pixels, so it is never X after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sof   <= 1'b0;
      t_out     <= '0;
      inv_t     <= '0;
      clamped   <= 1'b0;
    end else begin
      out_valid <= dv_valid[Q_BITS];
      out_sof   <= dv_sof[Q_BITS];
      if (dv_valid[Q_BITS]) begin
        t_out   <= dv_t[Q_BITS];
        inv_t   <= dv_q[Q_BITS];
        clamped <= dv_clamp[Q_BITS];
      end
    end
  end

endmodule

// File: tb/tb_te_transmission_recip.sv
// Directed bench for te_transmission_recip: reset, known vectors, clamp boundary,
// sof on a bubble, mid-stream reset, exhaustive sweep and a random stream.
module tb_te_transmission_recip;

  localparam int LAT = 17;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_sof;
  logic [9:0]  product;
  logic        out_valid;
  logic        out_sof;
  logic [10:0] t_out;
  logic [13:0] inv_t;
  logic        clamped;

  te_transmission_recip #(.T0(103), .Q_BITS(14)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sof    (in_sof),
    .product   (product),
    .out_valid (out_valid),
    .out_sof   (out_sof),
    .t_out     (t_out),
    .inv_t     (inv_t),
    .clamped   (clamped)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // expected entry: {sof, clamp, t[10:0], inv[13:0]}
  logic [26:0] exp_q[$];
  int          issue_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
  endtask

  // driver: called at a negedge, holds inputs for one sampling edge
  task automatic drive(input logic v, input logic s, input logic [9:0] p);
    int t;
    logic c;
    in_valid = v;
    in_sof   = s;
    product  = p;
    if (v) begin
      t = 1024 - int'(p);
      c = (t < 103);
      if (c) t = 103;
      exp_q.push_back({s, c, 11'(t), 14'(1048576 / t)});
      issue_q.push_back(cyc);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_sof   = 1'b0;
    product  = 10'd0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    chk(tag, 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard: compare every emerging pixel against the model and its issue cycle
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        logic [26:0] e;
        int          iss;
        e   = exp_q.pop_front();
        iss = issue_q.pop_front();
        chk("t_out",   32'(t_out),   32'(e[24:14]));
        chk("inv_t",   32'(inv_t),   32'(e[13:0]));
        chk("clamped", 32'(clamped), 32'(e[25]));
        chk("out_sof", 32'(out_sof), 32'(e[26]));
        chk("latency", 32'(cyc - iss), 32'(LAT));
        chk("inv_max", 32'(inv_t <= 14'd10180), 32'd1);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    product  = 10'd0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_sof",   32'(out_sof),   32'd0);
    chk("rst_t_out",     32'(t_out),     32'd0);
    chk("rst_inv_t",     32'(inv_t),     32'd0);
    chk("rst_clamped",   32'(clamped),   32'd0);
    rst_n = 1'b1;
    idle(2);

    // product 0: t = 1.0, exact latency
    drive(1'b1, 1'b1, 10'd0);
    idle(LAT - 2);
    chk("p0_early_valid", 32'(out_valid), 32'd0);
    idle(1);
    chk("p0_valid",   32'(out_valid), 32'd1);
    chk("p0_t_out",   32'(t_out),     32'd1024);
    chk("p0_inv_t",   32'(inv_t),     32'd1024);
    chk("p0_clamped", 32'(clamped),   32'd0);
    chk("p0_sof",     32'(out_sof),   32'd1);
    idle(2);
    chk("p0_bubble_valid", 32'(out_valid), 32'd0);
    wait_drain("drain_p0");

    // 512 -> 512/2048, 1000 -> clamped 103/10180
    drive(1'b1, 1'b0, 10'd512);
    drive(1'b1, 1'b0, 10'd1000);
    idle(LAT - 1);
    chk("p1000_t_out",   32'(t_out),   32'd103);
    chk("p1000_inv_t",   32'(inv_t),   32'd10180);
    chk("p1000_clamped", 32'(clamped), 32'd1);
    wait_drain("drain_basic");

    // clamp boundary back-to-back: 921 not clamped, 922 clamped
    drive(1'b1, 1'b0, 10'd921);
    drive(1'b1, 1'b0, 10'd922);
    idle(LAT - 2);
    chk("p921_t_out",   32'(t_out),   32'd103);
    chk("p921_inv_t",   32'(inv_t),   32'd10180);
    chk("p921_clamped", 32'(clamped), 32'd0);
    idle(1);
    chk("p922_t_out",   32'(t_out),   32'd103);
    chk("p922_clamped", 32'(clamped), 32'd1);
    wait_drain("drain_boundary");

    // sof on a bubble travels alone
    drive(1'b0, 1'b1, 10'd0);
    idle(LAT - 2);
    chk("bsof_early", 32'(out_sof), 32'd0);
    idle(1);
    chk("bsof_sof",   32'(out_sof),   32'd1);
    chk("bsof_valid", 32'(out_valid), 32'd0);
    idle(2);

    // mid-stream reset with five pixels in flight
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 10'(100 * i + 7));
    idle(3);
    rst_n = 1'b0;
    exp_q.delete();
    issue_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("mrst_valid", 32'(out_valid), 32'd0);
    chk("mrst_t_out", 32'(t_out),     32'd0);
    idle(LAT + 5);
    chk("mrst_quiet", 32'(out_valid), 32'd0);
    drive(1'b1, 1'b0, 10'd300);
    idle(LAT - 2);
    chk("mrst_early", 32'(out_valid), 32'd0);
    idle(1);
    chk("mrst_next_valid", 32'(out_valid), 32'd1);
    chk("mrst_next_t",     32'(t_out),     32'd724);
    wait_drain("drain_mrst");

    // exhaustive sweep, back-to-back
    for (int p = 0; p < 1024; p++) drive(1'b1, p == 0, 10'(p));
    idle(1);
    wait_drain("drain_sweep");

    // random stream with gaps
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      drive(1'b1, i == 0, 10'($urandom_range(0, 1023)));
    end
    idle(1);
    wait_drain("drain_stream");

    idle(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
